sub_bytes_iter: RTL

Iterative AES SubBytes stage that applies the S-box to all 16 bytes of a 128-bit state, `SBOX_LANES` bytes per clock, through a small bank of shared S-box instances. It sits directly upstream of the combinational ShiftRows stage in the round datapath: its `state_out` feeds ShiftRows' `state_in` unchanged. Valid/ready handshakes on both sides let the round controller stall it. The lane count trades area against latency.

---
 rtl/aes_pkg.sv | 63 ++++++
 rtl/aes_sbox.sv | 19 +
 rtl/sub_bytes_iter.sv | 106 ++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants: state geometry, SubBytes FSM states and S-box tables.
// The inverse S-box is compiled in only when SUB_BYTES_INV_EN is defined.
package aes_pkg;

  localparam int STATE_W   = 128;
  localparam int NUM_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sb_state_e;

  // Entry 0 sits in the top byte; entry n at bits [8*(255-n) +: 8].
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    return SBOX_FWD[{~b, 3'b000} +: 8];
  endfunction

`ifdef SUB_BYTES_INV_EN
  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox_inv(input logic [7:0] b);
    return SBOX_INV[{~b, 3'b000} +: 8];
  endfunction
`endif

endpackage

// File: rtl/aes_sbox.sv
// Combinational single-byte AES S-box lookup.
// With SUB_BYTES_INV_EN defined, 'inv' selects the inverse table.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_in,
`ifdef SUB_BYTES_INV_EN
  input  logic       inv,
`endif
  output logic [7:0] byte_out
);

`ifdef SUB_BYTES_INV_EN
  assign byte_out = inv ? sbox_inv(byte_in) : sbox_fwd(byte_in);
`else
  assign byte_out = sbox_fwd(byte_in);
`endif

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: SBOX_LANES bytes per cycle with valid/ready on both sides.
// Optional SUB_BYTES_INV_EN adds the inv_in port and inverse S-box tables.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int SBOX_LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] state_in,
`ifdef SUB_BYTES_INV_EN
  input  logic               inv_in,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] state_out
);

  localparam int GROUPS = NUM_BYTES / SBOX_LANES;
  localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int LANE_W = 8 * SBOX_LANES;

  if (!(SBOX_LANES == 1 || SBOX_LANES == 2 || SBOX_LANES == 4 ||
        SBOX_LANES == 8 || SBOX_LANES == 16)) begin : g_bad_lanes
    $error("sub_bytes_iter: SBOX_LANES must be 1, 2, 4, 8 or 16");
  end

  sb_state_e          state, state_n;
  logic [STATE_W-1:0] work, work_run;
  logic [CNT_W-1:0]   cnt;
  logic [LANE_W-1:0]  group_in, group_out;
  logic               last_grp, load;

  // Group k holds bytes b[k*L] .. b[k*L+L-1]; group 0 is the top slice.
  if (GROUPS == 1) begin : g_single
    assign group_in = work;
    assign work_run = group_out;
  end else begin : g_multi
    logic [0:GROUPS-1][LANE_W-1:0] grp, grp_run;
    assign grp      = work;
    assign group_in = grp[cnt];
    always_comb begin
      grp_run      = grp;
      grp_run[cnt] = group_out;
    end
    assign work_run = grp_run;
  end

`ifdef SUB_BYTES_INV_EN
  logic mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    mode <= 1'b0;
    else if (load) mode <= inv_in;
  end
`endif

  for (genvar j = 0; j < SBOX_LANES; j++) begin : g_lane
    aes_sbox u_sbox (
      .byte_in (group_in[LANE_W-1-8*j -: 8]),
`ifdef SUB_BYTES_INV_EN
      .inv     (mode),
`endif
      .byte_out(group_out[LANE_W-1-8*j -: 8])
    );
  end

  assign last_grp  = (cnt == CNT_W'(GROUPS - 1));
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign load      = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign state_out = out_valid ? work : '0;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (load) state_n = RUN;
      RUN:     if (last_grp) state_n = DONE;
      DONE:    if (out_ready) state_n = load ? RUN : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  // NOTE: the working register is plain flops, not a RAM, so it is cleared on reset like any other state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      work  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        work <= state_in;
        cnt  <= '0;
      end else if (state == RUN) begin
        work <= work_run;
        cnt  <= cnt + 1'b1;
      end
    end
  end

endmodule
